apb_reg_slave: RTL

APB completer (slave) that terminates one psel/addr/data/wr port of the APB interconnect. It holds a small bank of 32-bit registers behind a word-addressed map. It answers read and write transfers with pready, prdata and pslverr. It is the responder end of the interconnect's per-slave outputs, and one instance is used per slave slot.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_slv_regbank.sv | 28 ++
 rtl/apb_reg_slave.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register slave.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 12;
  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned ID_REG_IDX = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_slv_regbank.sv
// Word register bank; index 0 reads as the constant ID and ignores writes.
module apb_slv_regbank import apb_pkg::*; #(
  parameter int unsigned DATA_W   = APB_DATA_W,
  parameter int unsigned NUM_REGS = 8,
  parameter logic [DATA_W-1:0] ID_VALUE = DATA_W'(32'hA9B0_0001),
  localparam int unsigned IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i && (idx_i != IDX_W'(ID_REG_IDX))) begin
      regs_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = (idx_i == IDX_W'(ID_REG_IDX)) ? ID_VALUE : regs_q[idx_i];

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer fronting a small register bank.
// Optional wait states are built only when APB_SLV_WAIT_EN is defined.
module apb_reg_slave import apb_pkg::*; #(
  parameter int unsigned ADDR_W      = APB_ADDR_W,
  parameter int unsigned DATA_W      = APB_DATA_W,
  parameter int unsigned NUM_REGS    = 8,
  parameter logic [DATA_W-1:0] ID_VALUE = DATA_W'(32'hA9B0_0001),
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int unsigned IDX_W      = ADDR_W - 2;
  localparam int unsigned BANK_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  apb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;

  logic [IDX_W-1:0]  sel_idx_c;
  logic              sel_write_c;
  logic              sel_err_c;
  logic              we_c;
  logic              enter_access_c;
  logic [DATA_W-1:0] bank_rdata_c;
  logic              unused_c;

`ifdef APB_SLV_WAIT_EN
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign unused_c = ^paddr[1:0];
`else
  assign unused_c = ^{paddr[1:0], 32'(WAIT_CYCLES)};
`endif

  // In IDLE the setup-phase bus is decoded live so zero-wait responses are ready at the capture edge.
  assign sel_idx_c   = (state_q == IDLE) ? paddr[ADDR_W-1:2] : idx_q;
  assign sel_write_c = (state_q == IDLE) ? pwrite : write_q;
  assign sel_err_c   = (32'(sel_idx_c) >= NUM_REGS) ||
                       (sel_write_c && (sel_idx_c == IDX_W'(ID_REG_IDX)));

  apb_slv_regbank #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_regbank (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we_c),
    .idx_i   (BANK_IDX_W'(sel_idx_c)),
    .wdata_i (wdata_q),
    .rdata_o (bank_rdata_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    write_d        = write_q;
    wdata_d        = wdata_q;
    err_d          = err_q;
    pready_d       = 1'b0;
    pslverr_d      = 1'b0;
    prdata_d       = '0;
    we_c           = 1'b0;
    enter_access_c = 1'b0;
`ifdef APB_SLV_WAIT_EN
    cnt_d          = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          idx_d   = sel_idx_c;
          write_d = pwrite;
          wdata_d = pwdata;
          err_d   = sel_err_c;
`ifdef APB_SLV_WAIT_EN
          if (WAIT_CYCLES == 0) begin
            enter_access_c = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
`else
          enter_access_c = 1'b1;
`endif
        end
      end
      WAIT: begin
`ifdef APB_SLV_WAIT_EN
        if (!psel)                 state_d = IDLE;
        else if (cnt_q == '0)      enter_access_c = 1'b1;
        else                       cnt_d = cnt_q - CNT_W'(1);
`else
        state_d = IDLE;
`endif
      end
      ACCESS: begin
        state_d = IDLE;
        we_c    = psel && penable && write_q && !err_q;
      end
      default: state_d = IDLE;
    endcase

    if (enter_access_c) begin
      state_d   = ACCESS;
      pready_d  = 1'b1;
      pslverr_d = sel_err_c;
      prdata_d  = (sel_write_c || sel_err_c) ? '0 : bank_rdata_c;
    end
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

endmodule
